// File: rtl/layer_norm_arbiter_pkg.sv
// Shared types and constants for the LayerNorm engine arbiter: state encoding,
// Q-format widths/fractions and the grant index width helper.
package layer_norm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_e;

    localparam int LN_NUM_REQ        = 2;
    localparam int LN_D_MODEL        = 64;
    localparam int LN_X_WIDTH        = 16;  // Q5.10
    localparam int LN_X_FRAC         = 10;
    localparam int LN_Y_WIDTH        = 16;
    localparam int LN_PARAM_WIDTH    = 8;   // Q1.6
    localparam int LN_PARAM_FRAC     = 6;
    localparam int LN_TIMEOUT_CYCLES = 1024;

    // Never narrower than one bit, so single-bit selects stay legal.
    function automatic int grant_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin picker: first set request strictly after ptr_i,
// wrapping modulo N. Produces one-hot and encoded grants.
module rr_arbiter_core #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    always_comb begin
        logic [IW-1:0] idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_norm_arbiter.sv
// Round-robin sharing of one LayerNorm engine between NUM_REQ requesters.
// Optional engine watchdog enabled by defining LN_ARB_TIMEOUT_EN.
module layer_norm_arbiter
    import layer_norm_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = LN_NUM_REQ,
    parameter int D_MODEL        = LN_D_MODEL,
    parameter int X_WIDTH        = LN_X_WIDTH,
    parameter int Y_WIDTH        = LN_Y_WIDTH,
    parameter int PARAM_WIDTH    = LN_PARAM_WIDTH,
    parameter int TIMEOUT_CYCLES = LN_TIMEOUT_CYCLES,
    localparam int GIW           = grant_idx_width(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*D_MODEL*X_WIDTH-1:0] req_x_flat,
    input  logic [NUM_REQ*D_MODEL*PARAM_WIDTH-1:0] gamma_bank_flat,
    input  logic [NUM_REQ*D_MODEL*PARAM_WIDTH-1:0] beta_bank_flat,
    output logic                               eng_start,
    output logic [D_MODEL*X_WIDTH-1:0]         eng_x_flat,
    output logic [D_MODEL*PARAM_WIDTH-1:0]     eng_gamma_flat,
    output logic [D_MODEL*PARAM_WIDTH-1:0]     eng_beta_flat,
    input  logic                               eng_done,
    input  logic [D_MODEL*Y_WIDTH-1:0]         eng_y_flat,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [D_MODEL*Y_WIDTH-1:0]         rsp_y_flat,
    output logic                               rsp_error,
    output logic [GIW-1:0]                     grant_id,
    output logic                               busy
);

    localparam int XVEC_W = D_MODEL * X_WIDTH;
    localparam int YVEC_W = D_MODEL * Y_WIDTH;
    localparam int PVEC_W = D_MODEL * PARAM_WIDTH;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("layer_norm_arbiter: NUM_REQ must be within 2..8");
    end
    if (TIMEOUT_CYCLES < 2 || X_WIDTH <= LN_X_FRAC || PARAM_WIDTH <= LN_PARAM_FRAC) begin : g_bad_cfg
        $error("layer_norm_arbiter: inconsistent width/timeout configuration");
    end

    arb_state_e          state_q, state_d;
    logic [GIW-1:0]      ptr_q, ptr_d;
    logic [GIW-1:0]      grant_q, grant_d;
    logic [XVEC_W-1:0]   eng_x_q, eng_x_d;
    logic [YVEC_W-1:0]   rsp_y_q, rsp_y_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [GIW-1:0]      arb_idx;
    logic                arb_any;

    rr_arbiter_core #(
        .N  (NUM_REQ),
        .IW (GIW)
    ) u_rr (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

`ifdef LN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        eng_x_d   = eng_x_q;
        rsp_y_d   = rsp_y_q;
        req_ready = '0;
        eng_start = 1'b0;
`ifdef LN_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        rsp_err_d = rsp_err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready = arb_gnt;
                    grant_d   = arb_idx;
                    ptr_d     = arb_idx;
                    eng_x_d   = req_x_flat[arb_idx*XVEC_W +: XVEC_W];
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                eng_start = 1'b1;
                state_d   = ST_WAIT;
`ifdef LN_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_WAIT: begin
                if (eng_done) begin
                    rsp_y_d = eng_y_flat;
                    state_d = ST_RESPOND;
                end
`ifdef LN_ARB_TIMEOUT_EN
                // Engine never answered: report an error with a zeroed vector.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_y_d   = '0;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESPOND: begin
                if (rsp_ready[grant_q]) begin
                    state_d = ST_IDLE;
`ifdef LN_ARB_TIMEOUT_EN
                    rsp_err_d = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= GIW'(NUM_REQ - 1);
            grant_q <= '0;
            eng_x_q <= '0;
            rsp_y_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            eng_x_q <= eng_x_d;
            rsp_y_q <= rsp_y_d;
        end
    end

`ifdef LN_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_error = rsp_err_q;
`else
    assign rsp_error = 1'b0;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
        assign rsp_valid[gi] = (state_q == ST_RESPOND) && (grant_q == GIW'(gi));
    end

    assign eng_x_flat     = eng_x_q;
    assign rsp_y_flat     = rsp_y_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != ST_IDLE);
    assign eng_gamma_flat = gamma_bank_flat[grant_q*PVEC_W +: PVEC_W];
    assign eng_beta_flat  = beta_bank_flat[grant_q*PVEC_W +: PVEC_W];

endmodule

// File: doc/layer_norm_arbiter.md
Name: layer_norm_arbiter

Overview:
Shares one layer_norm_top engine between NUM_REQ independent requesters, e.g. the pre-attention and pre-FFN LayerNorm stages of a transformer block. Each requester hands over one feature vector with a valid/ready handshake. The arbiter grants requesters round-robin, captures the vector, pulses the engine start and waits for engine done. It then returns the normalised vector to the granted requester with its per-requester gamma/beta applied.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
D_MODEL, 64, elements per vector
X_WIDTH, 16, input element width (Q5.10)
Y_WIDTH, 16, output element width
PARAM_WIDTH, 8, gamma/beta element width (Q1.6)
TIMEOUT_CYCLES, 1024, engine watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot accept pulse
req_x_flat  in  NUM_REQ*D_MODEL*X_WIDTH  request vectors; requester r occupies slice r
gamma_bank_flat  in  NUM_REQ*D_MODEL*PARAM_WIDTH  per-requester gamma
beta_bank_flat  in  NUM_REQ*D_MODEL*PARAM_WIDTH  per-requester beta
eng_start  out  1  one-cycle engine start pulse
eng_x_flat  out  D_MODEL*X_WIDTH  captured vector sent to the engine
eng_gamma_flat  out  D_MODEL*PARAM_WIDTH  gamma of the granted requester
eng_beta_flat  out  D_MODEL*PARAM_WIDTH  beta of the granted requester
eng_done  in  1  engine done/valid pulse
eng_y_flat  in  D_MODEL*Y_WIDTH  engine result
rsp_valid  out  NUM_REQ  one-hot response valid
rsp_ready  in  NUM_REQ  per-requester response ready
rsp_y_flat  out  D_MODEL*Y_WIDTH  result, shared by all requesters
rsp_error  out  1  response is a timeout (always 0 without the optional feature)
grant_id  out  $clog2(NUM_REQ)  currently owning requester
busy  out  1  state != IDLE

Behaviour:
- Reset values: req_ready, rsp_valid, eng_start, rsp_error all 0; eng_x_flat, rsp_y_flat and grant_id 0; busy 0.
- Round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, LAUNCH, WAIT, RESPOND.
- IDLE:
  - If any req_valid is high, select the first set bit searching from ptr+1 upward, modulo NUM_REQ.
  - In the same cycle: pulse req_ready[g] combinationally, latch req_x_flat slice g into eng_x_flat at the clock edge, set grant_id=g and ptr=g.
  - Next state LAUNCH.
- LAUNCH: eng_start=1 for exactly this one cycle; next state WAIT.
- WAIT:
  - On eng_done, capture eng_y_flat into rsp_y_flat and go to RESPOND.
  - eng_done in any other state is ignored.
- RESPOND:
  - rsp_valid[grant_id]=1, held until rsp_ready[grant_id] is sampled high.
  - Then go to IDLE; rsp_valid drops on the following cycle.
- eng_gamma_flat and eng_beta_flat are combinational muxes of the banks by grant_id, stable from LAUNCH through WAIT.
- Latency: accept at cycle T, eng_start at T+1. rsp_valid appears one cycle after eng_done. If rsp_ready is already high, IDLE is re-entered the cycle after rsp_valid rises, so the next grant comes 1 cycle after the response.
- A requester that holds req_valid continuously does not starve the others; the pointer rotation guarantees this.
- No new grant is made while busy; the arbiter serves one vector at a time.
- rst_n asserted mid-operation: returns to IDLE immediately and drops rsp_valid. A lost response is acceptable. The engine shares rst_n.

Optional Feature:
- Macro: LN_ARB_TIMEOUT_EN.
- When defined: a cycle counter clears on entry to WAIT. If eng_done has not arrived after TIMEOUT_CYCLES cycles, go to RESPOND with rsp_error=1 and rsp_y_flat all zeros. rsp_error clears on the handshake.
- When undefined: no counter, WAIT is unbounded, and rsp_error is tied to 0.

Decomposition:
- Shared package: state encoding localparams, Q-format width/fraction constants, and the $clog2-based grant index width.
- One sub-module, rr_arbiter_core:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational, reusable by other shared-engine controllers.

Test Plan:
- Single request: req_valid=01, engine done 20 cycles after start -> req_ready[0] pulses once; eng_start 1 cycle later; rsp_valid=01 with rsp_y equal to eng_y; grant_id=0.
- Contention: req_valid=11 held for 4 vectors -> grants 0,1,0,1; each eng_gamma_flat matches that requester's bank.
- Response backpressure: rsp_ready[1]=0 for 10 cycles -> rsp_valid stays 10 and rsp_y stays stable; a pending req[0] is not granted until the handshake completes.
- Spurious eng_done asserted during IDLE and LAUNCH -> ignored; state and rsp_valid unchanged.
- Reset mid-WAIT: rst_n low for 2 cycles -> all outputs at reset values, busy=0; after release req_valid=10 is granted to requester 0? No: requester 0 is not requesting, so requester 1 is granted (pointer reset to NUM_REQ-1, search from 0 finds bit 1).
- LN_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and eng_done never asserted -> rsp_valid rises with rsp_error=1 and rsp_y=0; the next request is served normally.
